// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_decoder
// Description : Receive-side VGA timing recovery. Samples hsync/vsync from a
//               source in the same clock domain and rebuilds hpos/vpos with
//               flywheel counters that re-align on sync rising edges. Measured
//               line and frame lengths are compared with nominal timing to
//               drive a SEARCH -> HLOCK -> VARM -> LOCKED lock state machine.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_decoder #(
   parameter int H_TOTAL    = 800,
   parameter int V_TOTAL    = 525,
   parameter int H_DISPLAY  = 640,
   parameter int V_DISPLAY  = 480,
   parameter int H_EDGE_POS = 657,
   parameter int V_EDGE_POS = 491,
   parameter int H_TOL      = 2,
   parameter int V_TOL      = 0,
   parameter int LOCK_LINES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hsync_in,
   input  logic        vsync_in,
   output logic [9:0]  hpos,
   output logic [9:0]  vpos,
   output logic        display_on,
   output logic        locked,
   output logic        new_frame,
   output logic [10:0] line_len,
   output logic [9:0]  frame_lines
);

   // Counter limits and nominal timing, sized to the counters they meet.
   localparam logic [10:0] c_LCNT_MAX  = 11'd2047;
   localparam logic [9:0]  c_FCNT_MAX  = 10'd1023;
   localparam logic [10:0] c_H_TOTAL   = 11'(H_TOTAL);
   localparam logic [10:0] c_H_TOL     = 11'(H_TOL);
   localparam logic [9:0]  c_V_TOTAL   = 10'(V_TOTAL);
   localparam logic [9:0]  c_V_TOL     = 10'(V_TOL);
   localparam logic [9:0]  c_H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0]  c_V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0]  c_H_DISP    = 10'(H_DISPLAY);
   localparam logic [9:0]  c_V_DISP    = 10'(V_DISPLAY);
   // The source is one pixel further along by the time the edge is registered.
   localparam logic [9:0]  c_H_RESYNC  = 10'((H_EDGE_POS + 1) % H_TOTAL);
   localparam logic [9:0]  c_V_RESYNC  = 10'(V_EDGE_POS);
   localparam int          c_GW        = $clog2(LOCK_LINES + 1);
   localparam logic [c_GW-1:0] c_GCNT_ONE = c_GW'(1);
   localparam logic [c_GW-1:0] c_GCNT_LOCK = c_GW'(LOCK_LINES);

   typedef enum logic [1:0] {
      S_SEARCH = 2'd0,
      S_HLOCK  = 2'd1,
      S_VARM   = 2'd2,
      S_LOCKED = 2'd3
   } state_t;

   state_t          r_state;
   logic [c_GW-1:0] r_gcnt;
   logic            r_hs_q;
   logic            r_vs_q;
   logic            r_hseen;
   logic [10:0]     r_lcnt;
   logic [9:0]      r_fcnt;
   logic [9:0]      r_hpos;
   logic [9:0]      r_vpos;
   logic            r_display_on;
   logic            r_locked;
   logic            r_new_frame;
   logic [10:0]     r_line_len;
   logic [9:0]      r_frame_lines;

   logic            w_hrise;
   logic            w_vrise;
   logic            w_hwrap;
   logic            w_timeout;
   logic [10:0]     w_line_dev;
   logic [9:0]      w_frame_dev;
   logic            w_line_ok;
   logic            w_frame_ok;
   logic            w_line_bad;
   logic [c_GW-1:0] w_gcnt_inc;
   logic [9:0]      w_hpos_nxt;
   logic [9:0]      w_vpos_nxt;

   // Rising edges are seen in the same cycle as the first high sample.
   assign w_hrise   = hsync_in & ~r_hs_q;
   assign w_vrise   = vsync_in & ~r_vs_q;
   assign w_hwrap   = ~w_hrise & (r_hpos == c_H_LAST);
   assign w_timeout = (r_lcnt == c_LCNT_MAX);

   // Absolute deviation of the measured periods from nominal.
   assign w_line_dev  = (r_lcnt >= c_H_TOTAL) ? (r_lcnt - c_H_TOTAL) : (c_H_TOTAL - r_lcnt);
   assign w_frame_dev = (r_fcnt >= c_V_TOTAL) ? (r_fcnt - c_V_TOTAL) : (c_V_TOTAL - r_fcnt);

   // The very first hsync edge after reset has no preceding edge to measure from.
   assign w_line_ok  = r_hseen & (w_line_dev <= c_H_TOL);
   assign w_frame_ok = (w_frame_dev <= c_V_TOL);
   assign w_line_bad = w_hrise & ~w_line_ok;
   assign w_gcnt_inc = r_gcnt + c_GCNT_ONE;

   // Next flywheel position: sync edges snap, otherwise free-run with wrap.
   always_comb begin
      w_hpos_nxt = r_hpos + 10'd1;
      if (w_hrise) begin
         w_hpos_nxt = c_H_RESYNC;
      end else if (r_hpos == c_H_LAST) begin
         w_hpos_nxt = '0;
      end
      w_vpos_nxt = r_vpos;
      if (w_vrise) begin
         w_vpos_nxt = c_V_RESYNC;
      end else if (w_hwrap) begin
         w_vpos_nxt = (r_vpos == c_V_LAST) ? 10'd0 : (r_vpos + 10'd1);
      end
   end

   // Previous sync samples, first-edge flag and the frame-start pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hs_q      <= 1'b0;
         r_vs_q      <= 1'b0;
         r_hseen     <= 1'b0;
         r_new_frame <= 1'b0;
      end else begin
         r_hs_q      <= hsync_in;
         r_vs_q      <= vsync_in;
         r_new_frame <= w_vrise;
         if (w_hrise) begin
            r_hseen <= 1'b1;
         end
      end
   end

   // Clocks since the last hsync edge; saturation marks a lost hsync.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lcnt     <= '0;
         r_line_len <= '0;
      end else if (w_hrise) begin
         r_lcnt     <= 11'd1;
         r_line_len <= r_lcnt;
      end else if (r_lcnt != c_LCNT_MAX) begin
         r_lcnt <= r_lcnt + 11'd1;
      end
   end

   // Hsync edges per vsync period; a coincident hsync opens the new tally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fcnt        <= '0;
         r_frame_lines <= '0;
      end else if (w_vrise) begin
         r_frame_lines <= r_fcnt;
         r_fcnt        <= w_hrise ? 10'd1 : 10'd0;
      end else if (w_hrise && (r_fcnt != c_FCNT_MAX)) begin
         r_fcnt <= r_fcnt + 10'd1;
      end
   end

   // Recovered raster position.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hpos <= '0;
         r_vpos <= '0;
      end else begin
         r_hpos <= w_hpos_nxt;
         r_vpos <= w_vpos_nxt;
      end
   end

   // Lock state machine; line faults are judged ahead of frame faults, and
   // locked/display_on follow the state register by one clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_SEARCH;
         r_gcnt       <= '0;
         r_locked     <= 1'b0;
         r_display_on <= 1'b0;
      end else begin
         r_locked     <= (r_state == S_LOCKED);
         r_display_on <= (r_state == S_LOCKED) &&
                         (w_hpos_nxt < c_H_DISP) && (w_vpos_nxt < c_V_DISP);
         if (w_timeout || w_line_bad) begin
            r_state <= S_SEARCH;
            r_gcnt  <= '0;
         end else begin
            case (r_state)
               S_SEARCH: begin
                  if (w_hrise) begin
                     r_gcnt <= w_gcnt_inc;
                     if (w_gcnt_inc == c_GCNT_LOCK) begin
                        r_state <= S_HLOCK;
                     end
                  end
               end
               S_HLOCK: begin
                  // First vsync only arms the frame measurement.
                  if (w_vrise) begin
                     r_state <= S_VARM;
                  end
               end
               S_VARM: begin
                  if (w_vrise && w_frame_ok) begin
                     r_state <= S_LOCKED;
                  end
               end
               S_LOCKED: begin
                  if (w_vrise && !w_frame_ok) begin
                     r_state <= S_SEARCH;
                     r_gcnt  <= '0;
                  end
               end
               default: begin
                  r_state <= S_SEARCH;
                  r_gcnt  <= '0;
               end
            endcase
         end
      end
   end

   assign hpos        = r_hpos;
   assign vpos        = r_vpos;
   assign display_on  = r_display_on;
   assign locked      = r_locked;
   assign new_frame   = r_new_frame;
   assign line_len    = r_line_len;
   assign frame_lines = r_frame_lines;

endmodule
`default_nettype wire
